// File: rtl/pulse_bank.sv
// pulse_bank: C-channel phase-accumulator pulse generator with shadowed, wrap-committed freq/duty.
// Optional PULSE_BANK_SYNC_EN adds a global `sync` phase restart port.

module pulse_ch #(
    parameter int N = 32,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         wr,
    input  logic [1:0]   wr_sel,
    input  logic [N-1:0] wr_data,
`ifdef PULSE_BANK_SYNC_EN
    input  logic         sync,
`endif
    output logic [M-1:0] value,
    output logic         wrap
);
    localparam logic [M-1:0] HI = {1'b0, {(M-1){1'b1}}};
    localparam logic [M-1:0] LO = {1'b1, {(M-2){1'b0}}, 1'b1};

    logic [N-1:0] sh_freq, sh_duty, sh_off;
    logic [N-1:0] act_freq, act_duty;
    logic [N-1:0] phase;
    logic         pending;
    logic [N:0]   sum;
    logic         restart, commit, wr_pend;

`ifdef PULSE_BANK_SYNC_EN
    assign restart = sync;
`else
    assign restart = 1'b0;
`endif

    assign sum     = {1'b0, phase} + {1'b0, act_freq};
    assign wr_pend = wr && !wr_sel[1];
    // Shadow equals active whenever pending is clear, so a disabled channel may copy unconditionally.
    assign commit  = !en || (pending && (restart || sum[N]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_freq  <= '0;
            sh_duty  <= '0;
            sh_off   <= '0;
            act_freq <= '0;
            act_duty <= '0;
            phase    <= '0;
            pending  <= 1'b0;
            value    <= '0;
            wrap     <= 1'b0;
        end else begin
            if (wr) begin
                case (wr_sel)
                    2'd0:    sh_freq <= wr_data;
                    2'd1:    sh_duty <= wr_data;
                    2'd2:    sh_off  <= wr_data;
                    default: ;
                endcase
            end
            // Commit reads pre-write shadow; a same-cycle write keeps pending for the next wrap.
            if (commit) begin
                act_freq <= sh_freq;
                act_duty <= sh_duty;
            end
            pending <= wr_pend || (pending && !commit);
            phase   <= (!en || restart) ? sh_off : sum[N-1:0];
            wrap    <= en && !restart && sum[N];
            value   <= !en ? '0 : ((phase < act_duty) ? HI : LO);
        end
    end
endmodule

module pulse_bank #(
    parameter int C = 4,
    parameter int N = 32,
    parameter int M = 16,
    localparam int CW = (C > 1) ? $clog2(C) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [C-1:0]   en,
    input  logic           wr_en,
    input  logic [CW-1:0]  wr_ch,
    input  logic [1:0]     wr_sel,
    input  logic [N-1:0]   wr_data,
`ifdef PULSE_BANK_SYNC_EN
    input  logic           sync,
`endif
    output logic [C*M-1:0] value,
    output logic [C-1:0]   wrap
);
    logic [C-1:0][M-1:0] val_lane;

    assign value = val_lane;

    // Out-of-range wr_ch matches no lane, so such writes fall away.
    for (genvar c = 0; c < C; c++) begin : g_ch
        pulse_ch #(.N(N), .M(M)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[c]),
            .wr      (wr_en && (wr_ch == CW'(c))),
            .wr_sel  (wr_sel),
            .wr_data (wr_data),
`ifdef PULSE_BANK_SYNC_EN
            .sync    (sync),
`endif
            .value   (val_lane[c]),
            .wrap    (wrap[c])
        );
    end
endmodule

// File: tb/tb_pulse_bank.sv
// Scoreboard bench for pulse_bank: expectations queued per cycle/channel, checked at negedge.
// Sync checks are compiled only when PULSE_BANK_SYNC_EN is defined.

module tb_pulse_bank;
    localparam int C  = 5;
    localparam int N  = 32;
    localparam int M  = 16;
    localparam int CW = 3;
    localparam logic [M-1:0] HI = 16'h7FFF;
    localparam logic [M-1:0] LO = 16'h8001;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [C-1:0]   en;
    logic           wr_en;
    logic [CW-1:0]  wr_ch;
    logic [1:0]     wr_sel;
    logic [N-1:0]   wr_data;
`ifdef PULSE_BANK_SYNC_EN
    logic           sync;
`endif
    logic [C*M-1:0] value;
    logic [C-1:0]   wrap;

    pulse_bank #(.C(C), .N(N), .M(M)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
`ifdef PULSE_BANK_SYNC_EN
        .sync    (sync),
`endif
        .value   (value),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           at;
        int           ch;
        logic [M-1:0] val;
        logic         w;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;

    // Pattern chars: H/L = high/low level, h/l = same with wrap, M = mid (disabled/reset).
    task automatic expect_seq(input int base, input int ch, input string pat);
        exp_t e;
        for (int i = 0; i < pat.len(); i++) begin
            e.at = base + 1 + i;
            e.ch = ch;
            case (pat[i])
                "H": begin e.val = HI;  e.w = 1'b0; end
                "h": begin e.val = HI;  e.w = 1'b1; end
                "L": begin e.val = LO;  e.w = 1'b0; end
                "l": begin e.val = LO;  e.w = 1'b1; end
                default: begin e.val = '0; e.w = 1'b0; end
            endcase
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        int i;
        logic [M-1:0] av;
        logic         aw;
        i = 0;
        while (i < q.size()) begin
            if (q[i].at == cyc) begin
                av = value[q[i].ch*M +: M];
                aw = wrap[q[i].ch];
                tests++;
                if (av !== q[i].val || aw !== q[i].w) begin
                    failed++;
                    $display("FAIL ch%0d cyc%0d: value=%h wrap=%b, want value=%h wrap=%b",
                             q[i].ch, cyc, av, aw, q[i].val, q[i].w);
                end
                q.delete(i);
            end else if (q[i].at < cyc) begin
                tests++;
                failed++;
                $display("FAIL stale ch%0d cyc%0d: expectation never sampled", q[i].ch, q[i].at);
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int sel, input logic [N-1:0] d);
        wr_en   = 1'b1;
        wr_ch   = CW'(ch);
        wr_sel  = 2'(sel);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        int base;
        rst_n   = 1'b0;
        en      = '1;
        wr_en   = 1'b1;
        wr_ch   = '0;
        wr_sel  = 2'd0;
        wr_data = 32'h4000_0000;
`ifdef PULSE_BANK_SYNC_EN
        sync    = 1'b1;
`endif
        // Reset held 3 edges with enables/writes active, then one disabled edge.
        for (int c = 0; c < C; c++) expect_seq(0, c, "MMMM");
        repeat (3) tick();
        rst_n = 1'b1;
        en    = '0;
        wr_en = 1'b0;
`ifdef PULSE_BANK_SYNC_EN
        sync  = 1'b0;
`endif
        tick();

        // Ch0 basic 50% duty, period 4
        wr(0, 0, 32'h4000_0000);
        wr(0, 1, 32'h8000_0000);
        tick();
        en[0] = 1'b1;
        expect_seq(cyc, 0, "HHLlHHLl");
        repeat (8) tick();

        // Ch0 freq=0, duty=0: constant low, no wrap; MID while disabled
        en[0] = 1'b0;
        expect_seq(cyc, 0, "M");
        wr(0, 0, 32'h0);
        wr(0, 1, 32'h0);
        tick();
        en[0] = 1'b1;
        expect_seq(cyc, 0, "LLL");
        repeat (3) tick();

        // Ch0 all-ones duty starting at phase 2^N-1 with freq=1
        en[0] = 1'b0;
        wr(0, 0, 32'h1);
        wr(0, 1, 32'hFFFF_FFFF);
        wr(0, 2, 32'hFFFF_FFFF);
        tick();
        en[0] = 1'b1;
        expect_seq(cyc, 0, "lHH");
        repeat (3) tick();
        en[0] = 1'b0;

        // Ch1 freq change mid-period lands at the following wrap
        wr(1, 0, 32'h4000_0000);
        wr(1, 1, 32'h8000_0000);
        tick();
        en[1] = 1'b1;
        expect_seq(cyc, 1, "HHLlHHHHLLLlH");
        tick();
        wr(1, 0, 32'h2000_0000);
        repeat (11) tick();
        en[1] = 1'b0;

        // Ch2/ch3 180 degrees apart
        wr(2, 0, 32'h4000_0000);
        wr(2, 1, 32'h8000_0000);
        wr(2, 2, 32'h0);
        wr(3, 0, 32'h4000_0000);
        wr(3, 1, 32'h8000_0000);
        wr(3, 2, 32'h8000_0000);
        tick();
        en[2] = 1'b1;
        en[3] = 1'b1;
        base = cyc;
        expect_seq(base, 2, "HHLlHHLl");
        expect_seq(base, 3, "LlHHLlHH");
        repeat (8) tick();
`ifdef PULSE_BANK_SYNC_EN
        // Sync on the second following edge: ch3 would have wrapped there
        base = cyc;
        expect_seq(base, 2, "HHHHL");
        expect_seq(base, 3, "LLLlH");
        tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        repeat (3) tick();
`endif
        en[2] = 1'b0;
        en[3] = 1'b0;

        // Ch4: ignored writes (wr_ch = C, wr_sel = 3) must not disturb it
        wr(4, 0, 32'h4000_0000);
        wr(4, 1, 32'h8000_0000);
        wr(4, 2, 32'h0);
        wr(5, 0, 32'h1000_0000);
        wr(5, 1, 32'h0);
        wr(5, 2, 32'h4000_0000);
        wr(4, 3, 32'h4000_0000);
        tick();

        // Ch4: write coinciding with a wrap commit lands one wrap later
        en[4] = 1'b1;
        expect_seq(cyc, 4, "HHLlHHLlHHHHLLLlH");
        tick();
        wr(4, 1, 32'h8000_0000);
        tick();
        wr(4, 0, 32'h2000_0000);
        repeat (13) tick();

        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        if (q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/pulse_bank.md
# pulse_bank

Multi-channel pulse wave generator: C independent phase-accumulator channels, each with its own frequency, duty cycle and phase offset. Every channel drives a signed M-bit two-level waveform. Control words are written through one shared register port into per-channel shadow registers. A running channel takes new frequency/duty values only at its own phase wrap, so period changes are glitch-free. The block sits between the control/register interface and the waveform mixer/DAC path, and succeeds the single-channel pulse generator.

## Interface
- `C`, 4: number of channels (1..16).
- `N`, 32: phase accumulator and control word width.
- `M`, 16: output amplitude width (M ≥ 2).
- `CW` (localparam) = max(1, $clog2(C)): channel index width.

Ports, clock and reset first:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  C  per-channel run enable.
- `wr_en`  in  1  control write strobe, one write per cycle.
- `wr_ch`  in  CW  target channel; values ≥ C ignored.
- `wr_sel`  in  2  register select: 0 = freq, 1 = duty, 2 = phase offset, 3 = reserved (write ignored).
- `wr_data`  in  N  write data.
- `sync`  in  1  global phase restart; present only with PULSE_BANK_SYNC_EN.
- `value`  out  C*M  channel c occupies bits [c*M +: M]; signed amplitude.
- `wrap`  out  C  one-cycle pulse when channel's accumulator overflows.

## Operation
- Per-channel state:
  - shadow freq, duty, offset;
  - active freq, duty;
  - pending flag;
  - phase (N bits);
  - registered value and wrap.
- Write: when `wr_en` is high and `wr_ch` < C, store `wr_data` into the selected shadow register. A freq or duty write sets pending. An offset write does not set pending.
- HI = {0, 1…1} (0x7FFF at M=16). LO = {1, 0…0, 1} (0x8001). MID = 0.
- Running channel (en[c] = 1 for the previous and current cycle):
  - sum = {1'b0, phase} + active_freq, computed N+1 bits wide;
  - phase ← sum[N-1:0];
  - wrap[c] ← sum[N];
  - value ← (phase < active_duty) ? HI : LO, comparing the current (pre-update) phase, unsigned.
- Commit: when sum[N] = 1 and pending = 1, active freq/duty ← shadow values and pending is cleared. The new values apply from the next cycle.
- Write and commit in the same cycle for the same channel:
  - commit uses the shadow contents from before the write;
  - pending stays set;
  - the new value commits at the following wrap.
- Disabled channel (en[c] = 0):
  - phase ← shadow offset;
  - active ← shadow every cycle, pending cleared;
  - value ← MID;
  - wrap ← 0.
- Enable rising edge: the first running cycle starts from the offset phase loaded while disabled.
- freq = 0 while running: phase holds; output constant at HI or LO depending on duty; no wrap.
- duty = 0 gives constant LO. The all-ones duty gives HI except in the cycle where phase = 2^N − 1.
- Output frequency = f_clk · freq / 2^N. Duty fraction = duty / 2^N.

## Timing
- Reset (rst_n low at an edge) clears all shadow, active, pending, phase, `value` and `wrap` registers to 0. Reset overrides writes, enables and sync in the same cycle.
- Write to active latency:
  - disabled channel: 2 edges (shadow, then active);
  - running channel: the wrap edge following the write.
- `value` is registered; it reflects the phase held during the previous cycle (1-cycle latency).
- `wrap[c]` asserts in the same edge that loads the wrapped phase.
- Reset mid-period aborts all channels. After release, outputs read MID until channels are enabled.

## Configuration
- `PULSE_BANK_SYNC_EN` defined: the `sync` port exists. When sync = 1, every channel loads phase ← shadow offset and commits any pending shadow freq/duty. `wrap` is forced to 0 that cycle and `value` is computed from the pre-sync phase. Sync has priority over the normal accumulate/commit for running channels; disabled-channel behaviour is unchanged.
- `PULSE_BANK_SYNC_EN` undefined: no `sync` port and no associated logic. Channels re-phase only via `en`.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with en all ones and writes active → all `value` = 0 and `wrap` = 0 through release.
- Ch0, freq = 0x40000000, duty = 0x80000000, enable → `value` repeats 0x7FFF, 0x7FFF, 0x8001, 0x8001; `wrap[0]` asserts every 4th cycle.
- Running ch1 (freq = 0x40000000), write freq = 0x20000000 mid-period → old 4-cycle period completes; 8-cycle period starts after the next `wrap[1]`, with no short pulse.
- Ch2 and ch3 at the same freq, offsets 0 and 0x80000000, enabled together → waveforms 180° apart, wraps 2 cycles apart at freq = 0x40000000.
- Write with wr_ch = C, or with wr_sel = 3 → no channel state changes. Write coinciding with a wrap commit → new value lands one wrap later.
- With PULSE_BANK_SYNC_EN: pulse sync mid-period on all channels → all phases equal their offsets on the next cycle, and `wrap` is 0 in the sync cycle.
